// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, renderer state encoding and the
// 8-entry colour palette (RRGGBB, 2 bits per channel).
package tetris_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int CELL_PX    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAW,
    ST_DONE
  } render_state_e;

  // Index 0 is the empty cell and draws black, so a redraw also erases.
  localparam logic [5:0] PALETTE [8] = '{
    6'b000000, 6'b001111, 6'b111100, 6'b110011,
    6'b001100, 6'b110000, 6'b000011, 6'b111000
  };

endpackage

// File: rtl/cell_palette.sv
// Combinational colour-index to RRGGBB lookup, shared by the board and
// preview renderers.
module cell_palette
  import tetris_pkg::*;
(
  input  logic [2:0] idx,
  output logic [5:0] colour
);

  assign colour = PALETTE[idx];

endmodule

// File: rtl/board_renderer.sv
// Redraws the whole 10x20 board onto the VGA adapter, one 4x4 pixel square
// per cell, at a fixed 18 cycles per cell (fetch, wait, 16 plots).
module board_renderer
  import tetris_pkg::*;
#(
  parameter int X_ORIGIN = 60,
  parameter int Y_ORIGIN = 20,
  parameter int CELL_PX  = tetris_pkg::CELL_PX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] cell_col,
  output logic [4:0] cell_row,
  input  logic [2:0] cell_data,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [5:0] colour,
  output logic       writeEn
);

  render_state_e state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [1:0]    px_q, px_d;
  logic [1:0]    py_q, py_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    pal_colour;

  cell_palette u_palette (
    .idx    (idx_q),
    .colour (pal_colour)
  );

  // NOTE: every flop uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      py_q    <= py_d;
      idx_q   <= idx_d;
    end
  end

  logic last_col, last_row, last_px, last_py;
  assign last_col = (col_q == 4'(BOARD_COLS - 1));
  assign last_row = (row_q == 5'(BOARD_ROWS - 1));
  assign last_px  = (px_q == 2'(CELL_PX - 1));
  assign last_py  = (py_q == 2'(CELL_PX - 1));

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    py_d    = py_q;
    idx_d   = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        idx_d   = cell_data;
        px_d    = '0;
        py_d    = '0;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        px_d = px_q + 2'd1;
        if (last_px) py_d = py_q + 2'd1;
        if (last_px && last_py) begin
          if (last_col && last_row) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            col_d   = last_col ? 4'd0 : col_q + 4'd1;
            row_d   = last_col ? row_q + 5'd1 : row_q;
          end
        end
      end
      ST_DONE: begin
        // A held start chains straight into the next redraw.
        state_d = start ? ST_FETCH : ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    writeEn  = (state_q == ST_DRAW);
    cell_col = col_q;
    cell_row = row_q;
    X        = '0;
    Y        = '0;
    colour   = '0;
    if (state_q == ST_DRAW) begin
      X      = 8'(X_ORIGIN + CELL_PX * int'(col_q) + int'(px_q));
      Y      = 7'(Y_ORIGIN + CELL_PX * int'(row_q) + int'(py_q));
      colour = pal_colour;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: a behavioural board model predicts the
// timed pixel stream and done pulses; a negedge monitor compares them.
module tb_board_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, writeEn;
  logic [3:0] cell_col;
  logic [4:0] cell_row;
  logic [2:0] cell_data = '0;
  logic [7:0] X;
  logic [6:0] Y;
  logic [5:0] colour;

  board_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cell_col  (cell_col),
    .cell_row  (cell_row),
    .cell_data (cell_data),
    .X         (X),
    .Y         (Y),
    .colour    (colour),
    .writeEn   (writeEn)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM with one cycle of read latency.
  logic [2:0] ram [20][10];
  always @(posedge clk) begin
    if (cell_row < 20 && cell_col < 10) cell_data <= ram[cell_row][cell_col];
    else cell_data <= '0;
  end

  logic [5:0] ref_pal [8] = '{6'b000000, 6'b001111, 6'b111100, 6'b110011,
                              6'b001100, 6'b110000, 6'b000011, 6'b111000};

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } pix_t;

  pix_t pix_q[$];
  int   done_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Predict one redraw whose start is sampled at the end of cycle t0; only
  // events up to cycle 'limit' are expected (a reset cuts the rest).
  task automatic predict_run(input int t0, input int limit);
    pix_t p;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        for (int py = 0; py < 4; py++)
          for (int px = 0; px < 4; px++) begin
            p.cyc = t0 + 3 + 18 * (r * 10 + c) + 4 * py + px;
            p.x   = 60 + 4 * c + px;
            p.y   = 20 + 4 * r + py;
            p.col = int'(ref_pal[ram[r][c]]);
            if (p.cyc <= limit) pix_q.push_back(p);
          end
    if (t0 + 3601 <= limit) done_q.push_back(t0 + 3601);
  endtask

  always @(negedge clk) begin
    if (writeEn === 1'b1) begin
      n_vec++;
      if (pix_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: cyc=%0d X=%0d Y=%0d colour=%b, required none",
                 cyc, X, Y, colour);
      end else begin
        pix_t e;
        e = pix_q.pop_front();
        if (cyc != e.cyc || int'(X) != e.x || int'(Y) != e.y || int'(colour) != e.col) begin
          n_err++;
          $display("FAIL pixel: got cyc=%0d X=%0d Y=%0d colour=%b, required cyc=%0d X=%0d Y=%0d colour=%b",
                   cyc, X, Y, colour, e.cyc, e.x, e.y, 6'(e.col));
        end
      end
    end
    if (done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: cyc=%0d, required none", cyc);
      end else begin
        int e;
        e = done_q.pop_front();
        if (cyc != e) begin
          n_err++;
          $display("FAIL done_cycle: got %0d, required %0d", cyc, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    check({name, "_pix_left"}, pix_q.size(), 0);
    check({name, "_done_left"}, done_q.size(), 0);
    pix_q.delete();
    done_q.delete();
  endtask

  task automatic fill_ram(input int mode);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        ram[r][c] = (mode == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  int t0;

  initial begin
    fill_ram(0);
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_writeEn", writeEn, 0);
    check("rst_X", X, 0);
    check("rst_Y", Y, 0);
    check("rst_colour", colour, 0);
    check("rst_cell_col", cell_col, 0);
    check("rst_cell_row", cell_row, 0);
    reset = 1'b0;
    step(2);

    // Random board, with a stray start at cycle 1000 that must be ignored.
    t0 = cyc;
    predict_run(t0, 1 << 30);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    step(t0 + 1000 - cyc);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(t0 + 3602 - cyc);
    check("idle_after_done", busy, 0);
    step(20);
    drain("run_random");

    // Only the bottom-right cell is coloured.
    fill_ram(1);
    ram[19][9] = 3'd5;
    t0 = cyc;
    predict_run(t0, 1 << 30);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(t0 + 3620 - cyc);
    drain("run_corner");

    // Only the top-left cell is coloured.
    fill_ram(1);
    ram[0][0] = 3'd1;
    t0 = cyc;
    predict_run(t0, 1 << 30);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(t0 + 3620 - cyc);
    drain("run_origin");

    // Reset during cycle 500 abandons the redraw.
    fill_ram(0);
    t0 = cyc;
    predict_run(t0, t0 + 500);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(t0 + 500 - cyc);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_writeEn", writeEn, 0);
    step(40);
    check("midreset_busy_later", busy, 0);
    drain("run_reset");

    // Start held high chains a second redraw right after DONE.
    fill_ram(0);
    t0 = cyc;
    predict_run(t0, 1 << 30);
    predict_run(t0 + 3601, 1 << 30);
    start = 1'b1;
    step(t0 + 3602 - cyc);
    check("chain_busy_fetch", busy, 1);
    check("chain_writeEn_fetch", writeEn, 0);
    check("chain_cell_col", cell_col, 0);
    check("chain_cell_row", cell_row, 0);
    step(10);
    start = 1'b0;
    step(t0 + 7230 - cyc);
    check("chain_idle", busy, 0);
    drain("run_chain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter X_ORIGIN, default 60, meaning the screen x of the board's left pixel column.
REQ-002 SHALL have parameter Y_ORIGIN, default 20, meaning the screen y of the board's top pixel row.
REQ-003 SHALL have parameter CELL_PX, default 4, meaning the side of one square cell in pixels; only 4 is required to be supported.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk is the single clock and reset is synchronous active-high.
REQ-005 SHALL have port clk, input, 1, meaning the system clock (50 MHz).
REQ-006 SHALL have port reset, input, 1, meaning the synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning a request for a full-board redraw, sampled in IDLE only.
REQ-008 SHALL have port busy, output, 1, meaning the renderer is in any state other than IDLE.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse marking that the redraw is complete.
REQ-010 SHALL have port cell_col, output, 4, meaning the board RAM column address (0-9).
REQ-011 SHALL have port cell_row, output, 5, meaning the board RAM row address (0-19).
REQ-012 SHALL have port cell_data, input, 3, meaning the colour index read from the board RAM; it is valid 1 cycle after the address is presented.
REQ-013 SHALL have port X, output, 8, meaning the pixel x sent to the VGA adapter.
REQ-014 SHALL have port Y, output, 7, meaning the pixel y sent to the VGA adapter.
REQ-015 SHALL have port colour, output, 6, meaning the pixel colour in RRGGBB format, 2 bits per channel.
REQ-016 SHALL have port writeEn, output, 1, meaning the VGA adapter plot strobe.

Function
REQ-017 SHALL implement the states IDLE, FETCH, WAIT, DRAW and DONE.
REQ-018 SHALL move from IDLE to FETCH with col=0 and row=0 when start=1, and SHALL stay in IDLE otherwise.
REQ-019 SHALL drive cell_col/cell_row from the cell counters in FETCH, then SHALL go to WAIT.
REQ-020 SHALL, in WAIT, register cell_data as the current colour index, clear the pixel counters px/py (2 bits each), and go to DRAW.
REQ-021 SHALL, in DRAW, hold writeEn=1 for exactly 16 consecutive cycles, with px counting fastest and py advancing when px wraps from 3 to 0.
REQ-022 SHALL, in each DRAW cycle, output X=X_ORIGIN+4*col+px, Y=Y_ORIGIN+4*row+py, and colour=palette(index), all valid in the same cycle as writeEn.
REQ-023 SHALL, after the DRAW cycle with px=py=3, go to DONE if col=9 and row=19; otherwise it SHALL go to FETCH with col+1, wrapping col from 9 to 0 and incrementing row.
REQ-024 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL use a fixed timing of 18 cycles per cell: if start is sampled at cycle 0, the first writeEn is at cycle 3, the last writeEn is at cycle 3600, and done is at cycle 3601.
REQ-026 SHALL never let X exceed 159 or Y exceed 119 at the default parameters (maximum X=99, Y=99).
REQ-027 SHALL use the palette 0=000000 (empty, so it erases), 1=001111, 2=111100, 3=110011, 4=001100, 5=110000, 6=000011, 7=111000.
REQ-028 SHALL ignore start while busy=1, with no restart and no queuing.
REQ-029 SHALL hold writeEn=0 in every state other than DRAW.
REQ-030 SHALL, when start is held high continuously, begin a new redraw in the cycle after DONE.

Reset
REQ-031 SHALL, on reset, set state=IDLE, col=row=px=py=0, busy=0, done=0, writeEn=0, X=0, Y=0, colour=0 and cell_col=cell_row=0.
REQ-032 SHALL, when reset occurs mid-redraw, abandon the redraw at the next edge: no further writeEn and no done pulse.
REQ-033 SHALL give reset priority over start in the same cycle.

Structure
REQ-034 SHALL take BOARD_COLS=10, BOARD_ROWS=20, CELL_PX=4, the state encoding and the 8-entry palette table from shared package tetris_pkg.
REQ-035 SHALL place the palette lookup in one combinational sub-module, cell_palette (3-bit index in, 6-bit colour out), which is reused by the future preview renderer.

Verification
REQ-036 SHALL be verified with: reset, then start=1 for one cycle at cycle 0 -> writeEn first at cycle 3, exactly 3200 writeEn cycles in total, and done at cycle 3601 only.
REQ-037 SHALL be verified with: RAM all 0 except (col 9, row 19)=5 -> the last 16 writes are X=96..99, Y=96..99 with colour 110000, and all other writes have colour 000000.
REQ-038 SHALL be verified with: RAM (0,0)=1 -> the writes at cycles 3-6 are (60,20)..(63,20) with colour 001111, and the write at cycle 7 is (60,21).
REQ-039 SHALL be verified with: start pulsed again at cycle 1000 -> the pixel sequence is unchanged and exactly one done occurs.
REQ-040 SHALL be verified with: reset at cycle 500 -> writeEn=0 and busy=0 from cycle 501, with no done pulse.
REQ-041 SHALL be verified with: start held high -> a second redraw with FETCH at cycle 3602 and its first writeEn at cycle 3604.
